// File: rtl/led_pkg.sv
// led_pkg: shared types for the LED PWM controller.
// Config struct fields are sized for the widest supported build (PWM_W and
// RATE_W up to 16); narrower instances zero-extend on write.
package led_pkg;

    localparam int LED_MODE_W     = 2;
    localparam int LED_DUTY_MAX_W = 16;
    localparam int LED_RATE_MAX_W = 16;

    typedef enum logic [LED_MODE_W-1:0] {
        LED_OFF     = 2'd0,
        LED_STATIC  = 2'd1,
        LED_BLINK   = 2'd2,
        LED_BREATHE = 2'd3
    } led_mode_t;

    typedef struct packed {
        led_mode_t                 mode;
        logic [LED_DUTY_MAX_W-1:0] duty;
        logic [LED_RATE_MAX_W-1:0] rate;
    } led_cfg_t;

endpackage

// File: rtl/led_pwm_ctrl_if.sv
// led_pwm_ctrl_if: valid/ready configuration write port from the system
// controller (master) into the LED PWM controller (slave).
interface led_pwm_ctrl_if
    import led_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int PWM_W  = 8,
    parameter int RATE_W = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [CH_W-1:0]       cfg_ch;
    logic [LED_MODE_W-1:0] cfg_mode;
    logic [PWM_W-1:0]      cfg_duty;
    logic [RATE_W-1:0]     cfg_rate;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_duty, cfg_rate,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_duty, cfg_rate,
        output cfg_ready
    );

endinterface

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one LED channel. Shadow config is written any time; it is
// promoted to the active config only on frame_tick, so the level (and hence
// the PWM duty) never changes mid-period.
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int PWM_W  = 8,
    parameter int RATE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             frame_tick,
    input  logic             wr_en,
    input  led_cfg_t         wr_cfg,
    input  logic [PWM_W-1:0] cnt,
    output logic             pwm
);

    led_cfg_t          shadow;
    led_cfg_t          active;
    logic [RATE_W-1:0] step;
    logic              dir_down;
    logic              blink_on;
    logic [PWM_W-1:0]  level;
    logic [PWM_W-1:0]  duty;
    logic              step_due;
    logic              restart;

    assign duty     = active.duty[PWM_W-1:0];
    // Whole-struct compare: any difference in mode, duty or rate restarts the pattern.
    assign restart  = (shadow != active);
    assign step_due = (LED_RATE_MAX_W'(step) == active.rate);

    // Shadow register: last write before a frame boundary wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (wr_en) begin
            shadow <= wr_cfg;
        end
    end

    // Frame-rate pattern engine: commit or advance the level once per frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= '0;
            step     <= '0;
            dir_down <= 1'b0;
            blink_on <= 1'b0;
            level    <= '0;
        end else if (frame_tick) begin
            if (restart) begin
                active   <= shadow;
                step     <= '0;
                dir_down <= 1'b0;
                blink_on <= 1'b1;
                unique case (shadow.mode)
                    LED_STATIC, LED_BLINK: level <= shadow.duty[PWM_W-1:0];
                    default:               level <= '0;
                endcase
            end else begin
                step <= step_due ? '0 : step + 1'b1;
                unique case (active.mode)
                    LED_OFF:    level <= '0;
                    LED_STATIC: level <= duty;
                    LED_BLINK: begin
                        if (step_due) begin
                            blink_on <= !blink_on;
                            level    <= blink_on ? '0 : duty;
                        end
                    end
                    LED_BREATHE: begin
                        // Each endpoint is held for one step while the direction flips.
                        if (step_due) begin
                            if (!dir_down) begin
                                if (level == duty) dir_down <= 1'b1;
                                else               level    <= level + 1'b1;
                            end else begin
                                if (level == '0)   dir_down <= 1'b0;
                                else               level    <= level - 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // PWM compare, registered for a clean output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm <= 1'b0;
        end else begin
            pwm <= enable && (cnt < level);
        end
    end

endmodule

// File: rtl/led_pwm_ctrl.sv
// led_pwm_ctrl: multi-channel PWM LED controller. Owns the shared tick and
// frame timebase plus the config handshake; per-channel pattern state lives
// in led_pwm_channel. frame_tick is high in the cycle whose clock edge wraps
// cnt to 0, which is also the edge that commits new configs.
module led_pwm_ctrl
    import led_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int PWM_W     = 8,
    parameter int PRESC_DIV = 48,
    parameter int RATE_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    led_pwm_ctrl_if.slave     cfg,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              frame_tick
);

    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);

    logic [PRESC_W-1:0] presc;
    logic [PWM_W-1:0]   cnt;
    logic               tick;
    logic               ready_q;
    logic               xfer;
    led_cfg_t           wr_cfg;

    assign tick          = enable && (presc == PRESC_LAST);
    assign frame_tick    = tick && (cnt == '1);
    // Writes are refused only in the commit cycle so they never race the copy.
    assign cfg.cfg_ready = ready_q && !frame_tick;
    assign xfer          = cfg.cfg_valid && cfg.cfg_ready;

    // Prescaler: divides clk down to the PWM tick rate; frozen while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (enable) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    // PWM period counter, free-wrapping at 2**PWM_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Ready comes up on the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Widen the bus fields into the shared config struct.
    always_comb begin
        wr_cfg      = '0;
        wr_cfg.mode = led_mode_t'(cfg.cfg_mode);
        wr_cfg.duty = LED_DUTY_MAX_W'(cfg.cfg_duty);
        wr_cfg.rate = LED_RATE_MAX_W'(cfg.cfg_rate);
    end

    // Channel array; out-of-range cfg_ch values match no channel and are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_en;
        assign wr_en = xfer && (cfg.cfg_ch == CH_W'(i));

        led_pwm_channel #(
            .PWM_W  (PWM_W),
            .RATE_W (RATE_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .enable     (enable),
            .frame_tick (frame_tick),
            .wr_en      (wr_en),
            .wr_cfg     (wr_cfg),
            .cnt        (cnt),
            .pwm        (pwm_out[i])
        );
    end

endmodule

// File: doc/led_pwm_ctrl.md
Name: led_pwm_ctrl

Overview:
Parametrised multi-channel PWM LED controller that generates per-channel PWM waveforms with static, blink and breathe modes. It replaces hard-wired constant drive with a configurable level per channel. Its pwm_out bits feed the RGB hard-driver wrapper's PWM inputs (one bit per LED pad). The controller is configured at run time through a valid/ready write port from the system controller.

Parameters:
NUM_CH, 3, number of LED channels.
PWM_W, 8, PWM counter/duty width; period = 2**PWM_W ticks.
PRESC_DIV, 48, clk cycles per PWM tick (>=1).
RATE_W, 8, width of blink/breathe rate field.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
enable  in  1  global run; 0 freezes counters and forces pwm_out to 0.
cfg_valid  in  1  config write request.
cfg_ready  out  1  config write accept.
cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel.
cfg_mode  in  2  0 OFF, 1 STATIC, 2 BLINK, 3 BREATHE.
cfg_duty  in  PWM_W  peak/static duty.
cfg_rate  in  RATE_W  frames per step = cfg_rate+1.
pwm_out  out  NUM_CH  registered PWM bits.
frame_tick  out  1  one-cycle pulse at PWM period wrap.

Behaviour:
- Reset (async assert, sync release): all counters, shadow and active registers cleared, mode OFF, pwm_out=0, frame_tick=0, cfg_ready=0; cfg_ready=1 from the first clk edge after release.
- Prescaler: counts 0..PRESC_DIV-1 while enable=1; tick on terminal count. PRESC_DIV=1 makes every cycle a tick.
- PWM counter cnt: PWM_W bits, increments on tick, wraps 2**PWM_W-1 -> 0; frame_tick=1 the cycle cnt wraps to 0.
- pwm_out[i] registered: 1 iff enable && cnt < level[i] (1-cycle latency from cnt). level=0 -> always 0; level=2**PWM_W-1 -> high 2**PWM_W-1 of 2**PWM_W ticks.
- Config: a transfer happens when cfg_valid && cfg_ready; written into channel shadow registers (mode, duty, rate). cfg_ch >= NUM_CH: accepted, ignored. Writes to the same channel before commit: last one wins.
- Commit: on the frame_tick cycle, shadows copy to active registers, and mode-step counters and level restart for channels whose shadow changed. cfg_ready=0 during that single commit cycle; otherwise 1. Active level only changes at frame boundary (glitch-free).
- Per-channel modes, evaluated on each frame_tick, with step counter reaching cfg_rate:
  OFF: level=0.
  STATIC: level=duty.
  BLINK: level toggles between duty and 0 every rate+1 frames, starting at duty.
  BREATHE: level steps +1 every rate+1 frames from 0 up to duty, then -1 down to 0, repeat. Direction reverses at the endpoint; each endpoint is held one step. duty=0 -> constant 0.
- enable=0: prescaler, cnt, step counters hold; pwm_out=0; frame_tick=0; config still accepted (commit waits for next frame).
- Reset mid-frame: immediate clear; no partial state survives.

Decomposition:
- Package led_pkg: mode enum (LED_OFF, LED_STATIC, LED_BLINK, LED_BREATHE), channel config struct {mode, duty, rate}, mode field width constant.
- Sub-module led_pwm_channel: one per channel (generate loop). Holds shadow/active config, step counter, breathe direction, level, and the pwm compare register.
- Top holds prescaler, cnt, frame_tick, cfg handshake and channel decode.
- The hard-driver wrapper stays outside this block.

Test Plan:
- Reset then idle, PRESC_DIV=1, PWM_W=4 -> pwm_out=0, cfg_ready=1 one cycle after rst release, frame_tick every 16 cycles.
- STATIC ch0 duty=4 -> after next frame_tick, pwm_out[0] high exactly 4 of each 16 ticks; duty=0 -> never high; duty=15 -> high 15/16.
- BLINK ch1 duty=8 rate=1 -> pwm_out[1] active 2 frames (8/16 duty), silent 2 frames, repeating.
- BREATHE ch2 duty=3 rate=0 -> per-frame levels 0,1,2,3,3,2,1,0,0,1...
- cfg_valid held across frame_tick -> cfg_ready=0 on commit cycle only, write accepted next cycle and applied at the following frame; cfg_ch=3 (NUM_CH=3) ignored.
- enable=0 mid-frame for 10 cycles -> pwm_out=0, cnt frozen, resumes same cnt; rst asserted mid-BREATHE -> all outputs 0 immediately, mode OFF after release.
